// File: rtl/c3lib_ckg_pkg.sv
// -----------------------------------------------------------------------------
// c3lib_ckg_pkg
// Shared definitions for the clock-gating enable controller family.
//   ckg_state_e  : FSM state encoding, exported unchanged on the state port
//                  (OFF=0, WAKE=1, ON=2, DRAIN=3).
//   CKG_STATE_W  : width of the exported state bus.
// -----------------------------------------------------------------------------
package c3lib_ckg_pkg;

  localparam int CKG_STATE_W = 2;

  typedef enum logic [CKG_STATE_W-1:0] {
    CKG_OFF   = 2'd0,
    CKG_WAKE  = 2'd1,
    CKG_ON    = 2'd2,
    CKG_DRAIN = 2'd3
  } ckg_state_e;

endpackage

// File: rtl/c3lib_ckg_en_ctrl.sv
// -----------------------------------------------------------------------------
// c3lib_ckg_en_ctrl
// Registered clock-enable controller sitting one stage upstream of the
// negative-edge clock-gater cell. A request (req or force_on) wakes the gated
// clock, ack is raised once WAKE_CYC cycles have elapsed, and after the
// request drops the clock is held for idle_cnt_cfg cycles before gating off.
//
// Ports:
//   clk           free-running ungated clock (also drives the gater)
//   rst           synchronous reset, active-high
//   req           level activity request, four-phase with ack
//   force_on      debug/test override, behaves like a request
//   idle_cnt_cfg  idle hold-off in cycles, sampled on DRAIN entry
//   clk_en        registered enable to the gater
//   ack           registered acknowledge, high only in ON
//   state         FSM status (OFF=0, WAKE=1, ON=2, DRAIN=3)
// -----------------------------------------------------------------------------
module c3lib_ckg_en_ctrl
  import c3lib_ckg_pkg::*;
#(
  parameter int WAKE_CYC = 2,
  parameter int IDLE_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   force_on,
  input  logic [IDLE_W-1:0]      idle_cnt_cfg,
  output logic                   clk_en,
  output logic                   ack,
  output logic [CKG_STATE_W-1:0] state
);

  localparam logic [IDLE_W-1:0] WAKE_LOAD = IDLE_W'(WAKE_CYC - 1);
  localparam logic [IDLE_W-1:0] CNT_ONE   = IDLE_W'(1);

  ckg_state_e        cur_state;
  ckg_state_e        nxt_state;
  logic [IDLE_W-1:0] cnt;
  logic [IDLE_W-1:0] nxt_cnt;
  logic              act;

  assign act = req | force_on;

  // Next-state and counter logic. The one down-counter is shared: it times the
  // wake-up delay in WAKE and the idle hold-off in DRAIN. It is only reloaded
  // on entry to those states and only decremented while nonzero, so it never
  // wraps.
  always_comb begin
    nxt_state = cur_state;
    nxt_cnt   = cnt;
    case (cur_state)
      CKG_OFF: begin
        if (act) begin
          nxt_state = CKG_WAKE;
          nxt_cnt   = WAKE_LOAD;
        end
      end
      // WAKE is never aborted, even if the request drops; ON sorts it out.
      CKG_WAKE: begin
        if (cnt == '0) begin
          nxt_state = CKG_ON;
        end else begin
          nxt_cnt = cnt - CNT_ONE;
        end
      end
      CKG_ON: begin
        if (!act) begin
          if (idle_cnt_cfg == '0) begin
            nxt_state = CKG_OFF;
          end else begin
            nxt_state = CKG_DRAIN;
            nxt_cnt   = idle_cnt_cfg - CNT_ONE;
          end
        end
      end
      // A returning request wins over expiry and needs no wake delay because
      // the clock never stopped.
      CKG_DRAIN: begin
        if (act) begin
          nxt_state = CKG_ON;
        end else if (cnt == '0) begin
          nxt_state = CKG_OFF;
        end else begin
          nxt_cnt = cnt - CNT_ONE;
        end
      end
      default: begin
        nxt_state = CKG_OFF;
      end
    endcase
  end

  // State, counter and outputs. clk_en and ack are decoded from the next state
  // and registered alongside it, so both are pure flop outputs that change
  // only at posedge clk, ahead of the gater's negative-edge latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= CKG_OFF;
      cnt       <= '0;
      clk_en    <= 1'b0;
      ack       <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= nxt_cnt;
      clk_en    <= (nxt_state != CKG_OFF);
      ack       <= (nxt_state == CKG_ON);
    end
  end

  assign state = cur_state;

endmodule
